// File: rtl/cfg_mult_result_encoder_pkg.sv
// Shared definitions for the configurable low-precision multiplier's result encoder:
// mode codes, per-mode offset limits and the encoder state encoding.
package cfgmult_pkg;

  localparam logic [1:0] MODE_LO  = 2'b00;
  localparam logic [1:0] MODE_MED = 2'b01;
  localparam logic [1:0] MODE_HI  = 2'b10;

  localparam logic [2:0] MAXOFF_LOMED = 3'd6;
  localparam logic [2:0] MAXOFF_HI    = 3'd0;

  typedef enum logic [2:0] {IDLE, ABS, SHIFT, ROUND, DONE} enc_state_t;

  // Mode 11 is not a distinct format; it behaves like hi.
  function automatic logic [2:0] mode_maxoff(input logic [1:0] mode);
    return ((mode == MODE_LO) || (mode == MODE_MED)) ? MAXOFF_LOMED : MAXOFF_HI;
  endfunction

endpackage

// File: rtl/cfg_mult_result_encoder_if.sv
// Handshake bus between the accumulate stage, the result encoder and the operand consumer.
interface cfg_mult_result_encoder_if #(
  parameter int IN_W  = 17,
  parameter int SIG_W = 2,
  parameter int OFF_W = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_value;
  logic [1:0]              in_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sign;
  logic [SIG_W-1:0]        out_sig;
  logic [OFF_W-1:0]        out_off;
  logic                    out_zero;
  logic                    out_ovf;

  modport master (
    output in_valid, in_value, in_mode, out_ready,
    input  in_ready, out_valid, out_sign, out_sig, out_off, out_zero, out_ovf
  );

  modport slave (
    input  in_valid, in_value, in_mode, out_ready,
    output in_ready, out_valid, out_sign, out_sig, out_off, out_zero, out_ovf
  );
endinterface

// File: rtl/cfg_mult_result_encoder_round.sv
// Round-to-nearest-even of a normalized magnitude down to the significand field,
// folding a significand carry-out back into the offset when there is room.
module cfgmult_round #(
  parameter int MAG_W = 16,
  parameter int SIG_W = 2,
  parameter int OFF_W = 3
) (
  input  logic [MAG_W-1:0] mag,
  input  logic [OFF_W-1:0] cnt,
  output logic [SIG_W-1:0] sig,
  output logic [OFF_W-1:0] off,
  output logic             ovf
);

  localparam int GRD = MAG_W - SIG_W - 1;

  logic [SIG_W-1:0] trunc;
  logic             guard;
  logic             sticky;
  logic             up;

  function automatic logic rne_up(input logic g, input logic s, input logic lsb);
    return g & (s | lsb);
  endfunction

  always_comb begin
    trunc  = mag[MAG_W-1 -: SIG_W];
    guard  = mag[GRD];
    sticky = |mag[GRD-1:0];
    up     = rne_up(guard, sticky, trunc[0]);
    sig    = trunc;
    off    = cnt;
    ovf    = 1'b0;
    if (up) begin
      // A carry out of an all-ones significand undoes one left shift if any were taken;
      // otherwise the result pins at the largest code and flags saturation.
      if (&trunc) begin
        if (cnt != '0) begin
          sig = {1'b1, {(SIG_W-1){1'b0}}};
          off = cnt - 1'b1;
        end else begin
          ovf = 1'b1;
        end
      end else begin
        sig = trunc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfg_mult_result_encoder.sv
// Re-encodes a signed fixed-point multiplier sum into sign / significand / offset operand
// fields, normalizing one bit per cycle and rounding to nearest-even.
module cfg_mult_result_encoder
  import cfgmult_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int SIG_W = 2,
  parameter int OFF_W = 3
) (
  input logic                     clk,
  input logic                     reset,
  cfg_mult_result_encoder_if.slave bus
);

  localparam int MAG_W = IN_W - 1;
  localparam logic signed [IN_W-1:0] MIN_VAL = {1'b1, {MAG_W{1'b0}}};

  enc_state_t              state;
  logic signed [IN_W-1:0]  in_q;
  logic [OFF_W-1:0]        maxoff_q;
  logic [OFF_W-1:0]        cnt_q;
  logic [MAG_W-1:0]        mag_q;
  logic [MAG_W-1:0]        mag_abs;
  logic                    accept;
  logic                    shift_done;

  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    out_sign_q;
  logic [SIG_W-1:0]        out_sig_q;
  logic [OFF_W-1:0]        out_off_q;
  logic                    out_zero_q;
  logic                    out_ovf_q;

  logic [SIG_W-1:0]        rnd_sig;
  logic [OFF_W-1:0]        rnd_off;
  logic                    rnd_ovf;

  // The most negative sum has no positive twin in MAG_W bits, so it pins to all ones.
  function automatic logic [MAG_W-1:0] abs_sat(input logic signed [IN_W-1:0] v);
    logic signed [IN_W-1:0] n;
    n = -v;
    if (!v[IN_W-1])   return v[MAG_W-1:0];
    if (v == MIN_VAL) return '1;
    return n[MAG_W-1:0];
  endfunction

  assign accept     = (state == IDLE) && in_ready_q && bus.in_valid;
  assign mag_abs    = abs_sat(in_q);
  assign shift_done = mag_q[MAG_W-1] || (cnt_q == maxoff_q);

  cfgmult_round #(
    .MAG_W (MAG_W),
    .SIG_W (SIG_W),
    .OFF_W (OFF_W)
  ) u_round (
    .mag (mag_q),
    .cnt (cnt_q),
    .sig (rnd_sig),
    .off (rnd_off),
    .ovf (rnd_ovf)
  );

  // Datapath registers: only meaningful while a sum is in flight, so no reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (accept) begin
          in_q     <= bus.in_value;
          maxoff_q <= OFF_W'(mode_maxoff(bus.in_mode));
        end
      end
      ABS: begin
        mag_q <= mag_abs;
        cnt_q <= '0;
      end
      SHIFT: begin
        if (!shift_done) begin
          mag_q <= mag_q << 1;
          cnt_q <= cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control FSM and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_sig_q   <= '0;
      out_off_q   <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            in_ready_q <= 1'b0;
            state      <= ABS;
          end
        end
        ABS: begin
          if (mag_abs == '0) begin
            out_sign_q <= in_q[IN_W-1];
            out_sig_q  <= '0;
            out_off_q  <= '0;
            out_zero_q <= 1'b1;
            out_ovf_q  <= 1'b0;
            state      <= DONE;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_done) state <= ROUND;
        end
        ROUND: begin
          out_sign_q <= in_q[IN_W-1];
          out_sig_q  <= rnd_sig;
          out_off_q  <= rnd_off;
          out_zero_q <= 1'b0;
          out_ovf_q  <= rnd_ovf;
          state      <= DONE;
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_sig   = out_sig_q;
  assign bus.out_off   = out_off_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cfg_mult_result_encoder.sv
// Scoreboard bench for cfg_mult_result_encoder: an arithmetic reference model predicts
// each encoded result and its latency; a negedge monitor compares what the DUT presents.
module tb_cfg_mult_result_encoder;

  typedef struct {
    logic       sign;
    logic [1:0] sig;
    logic [2:0] off;
    logic       zero;
    logic       ovf;
    int         lat;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  bit   hold_low = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cfg_mult_result_encoder_if #(.IN_W(17), .SIG_W(2), .OFF_W(3)) bus ();

  cfg_mult_result_encoder #(.IN_W(17), .SIG_W(2), .OFF_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value arithmetic on the integer sum, not bit-level register behaviour.
  function automatic exp_t model(input logic [16:0] raw, input logic [1:0] mode);
    exp_t e;
    int v, m, maxoff, k, q, rem;
    bit up;
    v = int'(raw);
    if (raw[16]) v = v - 131072;
    m = (v < 0) ? -v : v;
    if (m > 65535) m = 65535;
    maxoff = (mode < 2) ? 6 : 0;
    e.sign = (v < 0);
    e.sig = 0; e.off = 0; e.zero = 0; e.ovf = 0; e.acc = 0;
    if (m == 0) begin
      e.zero = 1;
      e.lat  = 2;
      return e;
    end
    k = 0;
    while (m < 32768 && k < maxoff) begin
      m = m * 2;
      k++;
    end
    q   = m / 16384;
    rem = m % 16384;
    up  = (rem > 8192) || (rem == 8192 && (q % 2) == 1);
    if (up) q++;
    if (q == 4) begin
      if (k > 0) begin q = 2; e.off = 3'(k - 1); end
      else begin q = 3; e.ovf = 1; e.off = 0; end
    end else begin
      e.off = 3'(k);
    end
    e.sig = 2'(q);
    e.lat = 4 + k;
    return e;
  endfunction

  // Called at a negedge; returns at a negedge once the sum has been taken.
  task automatic send(input logic [16:0] v, input logic [1:0] m);
    exp_t e;
    int w = 0;
    while (!bus.in_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    e = model(v, m);
    e.acc = cyc + 1;
    sb.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_value = v;
    bus.in_mode  = m;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_value = 17'($urandom);
    bus.in_mode  = 2'($urandom);
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((sb.size() != 0 || bus.out_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [16:0] rand_val();
    logic [16:0] specials [8] = '{17'h00000, 17'h10000, 17'h0FFFF, 17'h1FFFF,
                                  17'h0E000, 17'h07000, 17'h06000, 17'h0A000};
    int base;
    case ($urandom_range(0, 4))
      0: return 17'($urandom);
      1: return 17'($urandom_range(1, 255) << $urandom_range(0, 8));
      2: begin
        base = $urandom_range(1, 255) << $urandom_range(0, 8);
        return 17'(-base);
      end
      3: return specials[$urandom_range(0, 7)];
      default: begin
        base = (($urandom_range(0, 3) << 14) | (1 << 13)) >> $urandom_range(0, 6);
        return 17'(base);
      end
    endcase
  endfunction

  // Consumer: random backpressure, or held off entirely for the stall test.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: new result on the first valid cycle, stability on every later one.
  initial begin
    bit         seen = 0;
    bit         prev_hs = 0;
    logic [7:0] held = '0;
    logic [7:0] cur;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        seen = 0;
        prev_hs = 0;
      end else begin
        if (prev_hs) seen = 0;
        cur = {bus.out_sign, bus.out_sig, bus.out_off, bus.out_zero, bus.out_ovf};
        if (bus.out_valid) begin
          if (!seen) begin
            if (sb.size() == 0) begin
              check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              check("out_sign", 32'(bus.out_sign), 32'(e.sign));
              check("out_sig",  32'(bus.out_sig),  32'(e.sig));
              check("out_off",  32'(bus.out_off),  32'(e.off));
              check("out_zero", 32'(bus.out_zero), 32'(e.zero));
              check("out_ovf",  32'(bus.out_ovf),  32'(e.ovf));
              check("latency",  32'(cyc - e.acc),  32'(e.lat));
            end
            held = cur;
            seen = 1;
          end else begin
            check("hold_stable", 32'(cur), 32'(held));
            check("in_ready_busy", 32'(bus.in_ready), 32'd0);
          end
        end
        prev_hs = bus.out_valid && bus.out_ready;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    bus.in_mode  = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_fields",    32'({bus.out_sign, bus.out_sig, bus.out_off, bus.out_zero, bus.out_ovf}), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    send(17'h0C000, 2'b00);
    send(17'h1F000, 2'b00);
    send(17'h07000, 2'b00);
    send(17'h0E000, 2'b00);
    send(17'h00003, 2'b10);
    send(17'h00003, 2'b00);
    send(17'h00000, 2'b01);
    send(17'h10000, 2'b11);
    wait_drain();

    // Stalled consumer: result must sit still and block new input.
    hold_low = 1'b1;
    @(negedge clk);
    send(17'h05555, 2'b01);
    begin
      int w = 0;
      while (!bus.out_valid && w < 30) begin
        @(negedge clk);
        w++;
      end
    end
    check("stall_valid", 32'(bus.out_valid), 32'd1);
    repeat (5) @(negedge clk);
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    check("stall_valid_held", 32'(bus.out_valid), 32'd1);
    hold_low = 1'b0;
    wait_drain();

    // Reset while normalizing: the in-flight result must vanish.
    bus.in_valid = 1'b1;
    bus.in_value = 17'h00003;
    bus.in_mode  = 2'b00;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_back", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midrst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    send(17'h1F000, 2'b00);

    for (int i = 0; i < 150; i++) send(rand_val(), 2'($urandom_range(0, 3)));
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
